// File: rtl/mem_ctrl.sv
// mem_ctrl: front-panel load/check sequencer plus CPU memory access port.
// Optional key debounce is compiled in with `define MEM_CTRL_DEBOUNCE_EN.
module mem_ctrl #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cpustate,
  input  logic        key,
  input  logic [7:0]  sw,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [4:0]  load_cnt,
  output logic [7:0]  check_data,
  output logic        full
);

  typedef enum logic [2:0] {IDLE, LD, CK, CR, CRD, CW} state_t;

  state_t      r_state, w_next;
  logic        r_s1, r_s2;
  logic [1:0]  r_cs_prev;
  logic [4:0]  r_load_cnt;
  logic        r_full;
  logic [7:0]  r_check_data, r_cpu_rdata, r_sw, r_wdata;
  logic [15:0] r_addr;
  logic        w_press, w_cs_chg;

  assign w_cs_chg   = (cpustate != r_cs_prev);
  assign load_cnt   = r_load_cnt;
  assign full       = r_full;
  assign check_data = r_check_data;
  assign cpu_rdata  = r_cpu_rdata;

  // Key synchronizer and mode history register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_cs_prev <= cpustate;
    end else begin
      r_s1      <= key;
      r_s2      <= r_s1;
      r_cs_prev <= cpustate;
    end
  end

`ifdef MEM_CTRL_DEBOUNCE_EN
  logic [7:0] r_deb_cnt;
  logic       r_deb_fired;

  assign w_press = ~r_s2 & ~r_deb_fired & (r_deb_cnt == 8'(DEB_CYCLES - 1));

  // Count consecutive low samples; fire once, re-arm when the key goes high
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_deb_cnt   <= '0;
      r_deb_fired <= 1'b0;
    end else if (r_s2) begin
      r_deb_cnt   <= '0;
      r_deb_fired <= 1'b0;
    end else if (!r_deb_fired) begin
      if (w_press) begin
        r_deb_cnt   <= '0;
        r_deb_fired <= 1'b1;
      end else begin
        r_deb_cnt <= r_deb_cnt + 8'd1;
      end
    end
  end
`else
  // Raw falling edge; DEB_CYCLES has no effect here, the always-true term only keeps it referenced
  assign w_press = ~r_s1 & r_s2 & (DEB_CYCLES >= 32'd2);
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and Moore memory/ack outputs
  always_comb begin
    w_next    = r_state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cs_chg) begin
          if (cpustate == 2'b01 && w_press)      w_next = LD;
          else if (cpustate == 2'b10 && w_press) w_next = CK;
          else if (cpustate == 2'b11 && cpu_req) w_next = cpu_we ? CW : CR;
        end
      end
      LD: begin
        mem_we    = 1'b1;
        mem_addr  = {11'b0, r_load_cnt};
        mem_wdata = r_sw;
        w_next    = IDLE;
      end
      CK: begin
        mem_re   = 1'b1;
        mem_addr = {11'b0, r_load_cnt};
        w_next   = IDLE;
      end
      CR: begin
        mem_re   = 1'b1;
        mem_addr = r_addr;
        w_next   = w_cs_chg ? IDLE : CRD;
      end
      CRD: begin
        cpu_ack = 1'b1;
        w_next  = IDLE;
      end
      CW: begin
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        cpu_ack   = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, load pointer, full flag and read-data registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_load_cnt   <= '0;
      r_full       <= 1'b0;
      r_check_data <= '0;
      r_cpu_rdata  <= '0;
      r_sw         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      if (r_state == IDLE && w_next == LD) r_sw <= sw;
      if (r_state == IDLE && (w_next == CR || w_next == CW)) begin
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
      if (r_state == CK) r_check_data <= mem_rdata;
      if (r_state == CR && w_next == CRD) r_cpu_rdata <= mem_rdata;
      if (w_cs_chg) begin
        r_load_cnt <= '0;
      end else if (r_state == LD) begin
        r_load_cnt <= r_load_cnt + 5'd1;
        if (r_load_cnt == 5'd31) r_full <= 1'b1;
      end else if (r_state == CK) begin
        r_load_cnt <= r_load_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected strobes/acks,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_ctrl;
`ifdef MEM_CTRL_DEBOUNCE_EN
  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 10;
`else
  localparam int unsigned DEB  = 16;
  localparam int unsigned HOLD = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  cpustate = 2'b00;
  logic        key = 1'b1;
  logic [7:0]  sw = '0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata = '0;
  logic [4:0]  load_cnt;
  logic [7:0]  check_data;
  logic        full;

  int checks = 0;
  int failures = 0;

  logic [23:0] wq[$];  // {addr, data}
  logic [15:0] rq[$];  // addr
  logic [8:0]  aq[$];  // {is_read, rdata}

  mem_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .cpustate(cpustate), .key(key), .sw(sw),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .load_cnt(load_cnt), .check_data(check_data), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented strobe/ack must match the head of its queue
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_write", {8'h0, mem_addr, mem_wdata}, 32'hFFFFFFFF);
        else begin
          logic [23:0] e;
          e = wq.pop_front();
          chk("write", {8'h0, mem_addr, mem_wdata}, {8'h0, e});
        end
      end
      if (mem_re) begin
        if (rq.size() == 0) chk("unexpected_read", {16'h0, mem_addr}, 32'hFFFFFFFF);
        else begin
          logic [15:0] e;
          e = rq.pop_front();
          chk("read_addr", {16'h0, mem_addr}, {16'h0, e});
        end
      end
      if (cpu_ack) begin
        if (aq.size() == 0) chk("unexpected_ack", {23'h0, cpu_ack}, 32'h0);
        else begin
          logic [8:0] e;
          e = aq.pop_front();
          if (e[8]) chk("ack_read", {23'h0, mem_we, cpu_rdata}, {23'h0, 1'b0, e[7:0]});
          else      chk("ack_write", {31'h0, mem_we}, 32'h1);
        end
      end
    end
  end

  task automatic press(input int unsigned hold);
    key = 1'b0;
    repeat (hold) @(negedge clk);
    key = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  logic [4:0] exp_ptr;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_we", {31'h0, mem_we}, 0);
    chk("rst_re", {31'h0, mem_re}, 0);
    chk("rst_addr", {16'h0, mem_addr}, 0);
    chk("rst_wdata", {24'h0, mem_wdata}, 0);
    chk("rst_ack", {31'h0, cpu_ack}, 0);
    chk("rst_cnt", {27'h0, load_cnt}, 0);
    chk("rst_full", {31'h0, full}, 0);
    chk("rst_chk", {24'h0, check_data}, 0);
    chk("rst_rdata", {24'h0, cpu_rdata}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // IN mode: single load of A5 at address 0
    cpustate = 2'b01;
    repeat (2) @(negedge clk);
    sw = 8'hA5;
    wq.push_back({16'h0000, 8'hA5});
    press(HOLD);
    chk("cnt_after_1", {27'h0, load_cnt}, 1);
    chk("full_after_1", {31'h0, full}, 0);

    // Fill the remaining 31 words, then wrap
    exp_ptr = 5'd1;
    for (int i = 1; i < 32; i++) begin
      sw = 8'(i * 3 + 1);
      wq.push_back({11'h0, exp_ptr, sw});
      exp_ptr = exp_ptr + 5'd1;
      press(HOLD);
    end
    chk("cnt_after_32", {27'h0, load_cnt}, 0);
    chk("full_after_32", {31'h0, full}, 1);
    sw = 8'h5A;
    wq.push_back({16'h0000, 8'h5A});
    press(HOLD);
    chk("cnt_after_33", {27'h0, load_cnt}, 1);
    chk("full_sticky", {31'h0, full}, 1);

    // CHECK mode: pointer clears on mode change, read address 0
    cpustate = 2'b10;
    mem_rdata = 8'h3C;
    repeat (2) @(negedge clk);
    chk("cnt_cleared_ck", {27'h0, load_cnt}, 0);
    rq.push_back(16'h0000);
    press(HOLD);
    chk("check_data", {24'h0, check_data}, 32'h3C);
    chk("cnt_after_ck", {27'h0, load_cnt}, 1);

    // RUN: key press ignored
    cpustate = 2'b11;
    repeat (2) @(negedge clk);
    press(HOLD);
    chk("cnt_run_press", {27'h0, load_cnt}, 0);

    // RUN: CPU read, 2-cycle latency
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; mem_rdata = 8'h77;
    rq.push_back(16'h0040);
    aq.push_back({1'b1, 8'h77});
    @(negedge clk);
    chk("rd_re_c1", {31'h0, mem_re}, 1);
    chk("rd_ack_c1", {31'h0, cpu_ack}, 0);
    @(negedge clk);
    chk("rd_ack_c2", {31'h0, cpu_ack}, 1);
    chk("rd_rdata", {24'h0, cpu_rdata}, 32'h77);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_c3", {31'h0, cpu_ack}, 0);

    // RUN: back-to-back writes complete every 2 cycles
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h99;
    repeat (2) begin
      wq.push_back({16'h1234, 8'h99});
      aq.push_back({1'b0, 8'h00});
    end
    @(negedge clk);
    chk("wr_ack_c1", {31'h0, cpu_ack}, 1);
    @(negedge clk);
    chk("wr_ack_c2", {31'h0, cpu_ack}, 0);
    @(negedge clk);
    chk("wr_ack_c3", {31'h0, cpu_ack}, 1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (2) @(negedge clk);

    // RUN: read aborted by a mode change while in CR
    cpu_req = 1'b1; cpu_addr = 16'h0080;
    rq.push_back(16'h0080);
    @(negedge clk);
    cpustate = 2'b10; cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_ack", {31'h0, cpu_ack}, 0);
    chk("abort_re", {31'h0, mem_re}, 0);
    chk("abort_cnt", {27'h0, load_cnt}, 0);
    repeat (3) @(negedge clk);
    mem_rdata = 8'hC3;
    rq.push_back(16'h0000);
    press(HOLD);
    chk("check_after_abort", {24'h0, check_data}, 32'hC3);

    // IN mode: cpu_req never acked
    cpustate = 2'b01;
    cpu_req = 1'b1; cpu_we = 1'b1;
    repeat (6) @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a RUN read
    cpustate = 2'b11;
    repeat (2) @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123;
    rq.push_back(16'h0123);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_ack", {31'h0, cpu_ack}, 0);
    chk("rstmid_re", {31'h0, mem_re}, 0);
    chk("rstmid_full", {31'h0, full}, 0);
    cpu_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

`ifdef MEM_CTRL_DEBOUNCE_EN
    // Debounce: 3-cycle glitch ignored, 10-cycle press writes once
    cpustate = 2'b01;
    sw = 8'hE7;
    repeat (2) @(negedge clk);
    key = 1'b0;
    repeat (3) @(negedge clk);
    key = 1'b1;
    repeat (6) @(negedge clk);
    chk("deb_glitch_cnt", {27'h0, load_cnt}, 0);
    wq.push_back({16'h0000, 8'hE7});
    press(10);
    chk("deb_press_cnt", {27'h0, load_cnt}, 1);
`endif

    repeat (4) @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("aq_drained", aq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive low samples a key press must last when debounce is compiled in; range 2..255.
REQ-002 clk  in  1  system clock, single clock domain, rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 cpustate  in  2  mode: 00 idle, 01 IN, 10 CHECK, 11 RUN.
REQ-005 key  in  1  front-panel load/step button, low when pressed.
REQ-006 sw  in  8  switch word written to memory in IN mode.
REQ-007 cpu_req / cpu_we  in  1 / 1  CPU access request, held until ack; 1 = write.
REQ-008 cpu_addr / cpu_wdata  in  16 / 8  CPU address and write data, stable while cpu_req high.
REQ-009 cpu_ack / cpu_rdata  out  1 / 8  one-cycle completion pulse; registered read data.
REQ-010 mem_addr / mem_wdata  out  16 / 8  memory address and write data.
REQ-011 mem_we / mem_re / mem_rdata  out / out / in  1 / 1 / 8  memory write strobe, read strobe, combinational read data.
REQ-012 load_cnt / check_data / full  out  5 / 8 / 1  load pointer, last checked word, load-wrapped flag.

Function
REQ-013 Press detect: two-flop sync of key (s1, s2); press = ~s1 & s2, a one-cycle pulse.
REQ-014 FSM states IDLE, LD, CK, CR, CRD, CW; mem_we, mem_re, mem_addr, and mem_wdata are Moore outputs decoded from state and registered operands.
REQ-015 IDLE, cpustate=01, press: capture sw, go to LD; LD drives mem_we=1, mem_addr={11'b0,load_cnt}, captured sw; next cycle load_cnt+1, return IDLE.
REQ-016 IDLE, cpustate=10, press: go to CK; CK drives mem_re=1, mem_addr={11'b0,load_cnt}; next cycle check_data<=mem_rdata, load_cnt+1, return IDLE.
REQ-017 load_cnt wraps 31->0; on the 31->0 increment in LD only, full sets and stays set until reset.
REQ-018 IDLE, cpustate=11, cpu_req=1, cpu_we=1: go to CW; CW drives mem_we=1, cpu_addr, cpu_wdata, and cpu_ack=1 in the same cycle, then returns to IDLE.
REQ-019 IDLE, cpustate=11, cpu_req=1, cpu_we=0: CR drives mem_re=1, mem_addr=cpu_addr; CRD loads cpu_rdata<=mem_rdata, asserts cpu_ack=1, returns IDLE; read latency is 2 cycles from the req sample.
REQ-020 cpu_req still high in the cycle after cpu_ack starts a new transaction; back-to-back writes complete every 2 cycles.
REQ-021 Key presses are ignored in RUN and 00; cpu_req is ignored (never acked) outside RUN.
REQ-022 A press arriving while the FSM is not in IDLE is dropped; no queueing.
REQ-023 A registered cs_prev tracks cpustate; when cpustate != cs_prev, the FSM goes to IDLE next cycle, load_cnt clears to 0, and no ack or increment is issued for any aborted CR.
REQ-024 Outside LD/CW, mem_we=0; outside CK/CR, mem_re=0; mem_addr and mem_wdata are 0 in IDLE.

Reset
REQ-025 With reset=0 at a clk edge: FSM=IDLE, s1=s2=1, load_cnt=0, full=0, check_data=0, cpu_rdata=0, cpu_ack=0, cs_prev=cpustate, debounce counter=0.
REQ-026 Reset mid-transaction aborts it: no ack, no strobe in the following cycle.

Configuration
REQ-027 Macro MEM_CTRL_DEBOUNCE_EN defined: press fires once when s2 has been low for DEB_CYCLES consecutive cycles; re-arms only after s2 returns high for at least one cycle.
REQ-028 Macro MEM_CTRL_DEBOUNCE_EN undefined: press is the raw edge of REQ-013, and no debounce counter is instantiated.

Verification
REQ-029 IN mode, sw=8'hA5, one key press -> one cycle with mem_we=1, mem_addr=0, mem_wdata=A5; load_cnt becomes 1.
REQ-030 IN mode, 32 presses -> addresses 0..31 written, load_cnt=0, full=1; 33rd press writes address 0.
REQ-031 Switch IN to CHECK, mem_rdata=8'h3C, one press -> mem_re=1 at address 0, check_data=3C, load_cnt=1.
REQ-032 RUN, cpu_req=1, cpu_we=0, cpu_addr=16'h0040, mem_rdata=8'h77 -> mem_re 1 cycle later, cpu_ack=1 and cpu_rdata=77 2 cycles after the req sample.
REQ-033 RUN, read in CR, cpustate changed to 10 -> no cpu_ack, FSM=IDLE, load_cnt=0; a key press during RUN -> no memory strobe.
REQ-034 With MEM_CTRL_DEBOUNCE_EN defined and DEB_CYCLES=4: a 3-cycle low glitch -> no press; a 10-cycle low -> exactly one write.
